// File: rtl/pixel_stream_tx_if.sv
// Bundle of the frame request, frame RAM read port and tagged stream output
// of the pixel stream source. The master side is the source itself.
interface pixel_stream_tx_if #(
   parameter int ADDR_WIDTH = 19,
   parameter int DATA_WIDTH = 10
);
   logic                  start;
   logic [9:0]            image_width;
   logic [9:0]            image_height;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [7:0]            mem_rdata;
   logic                  refresh;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  busy;
   logic                  done;

   modport master (
      input  start, image_width, image_height, mem_rdata,
      output mem_addr, refresh, data_out, busy, done
   );

   modport slave (
      output start, image_width, image_height, mem_rdata,
      input  mem_addr, refresh, data_out, busy, done
   );
endinterface

// File: rtl/pixel_stream_tx.sv
// Frame-to-stream source: reads a WxH 8-bit image from a synchronous frame RAM
// in raster order and emits refresh, tagged pixel words, flush words and one
// end-of-frame word into the filter chain. No backpressure.
module pixel_stream_tx #(
   parameter int                     TAG_WIDTH    = 2,
   parameter logic [TAG_WIDTH-1:0]   INVALID_TAG  = 2'd0,
   parameter logic [TAG_WIDTH-1:0]   DATA_TAG0    = 2'd1,
   parameter logic [TAG_WIDTH-1:0]   DATA_TAG1    = 2'd2,
   parameter logic [TAG_WIDTH-1:0]   DATA_END_TAG = 2'd3,
   parameter int                     DATA_WIDTH   = 8 + TAG_WIDTH,
   parameter int                     ADDR_WIDTH   = 19,
   parameter int                     FLUSH_LINES  = 4
) (
   input  logic               clk,
   input  logic               rst,
   pixel_stream_tx_if.master  bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REFRESH,
      S_STREAM,
      S_FLUSH,
      S_END
   } state_t;

   state_t                state_q, state_d;
   logic [9:0]            w_q, w_d, h_q, h_d;
   logic [9:0]            col_q, col_d, row_q, row_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   // Tag of the address being issued, and the same tag one cycle later
   // (aligned with the RAM read data).
   logic [TAG_WIDTH-1:0]  tag_a_q, tag_a_d, tag_b_q;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   // Remaining FLUSH cycles; two extra cycles cover the read pipeline.
   logic [15:0]           flush_q, flush_d;
   logic                  accept;
   logic                  last_pix;

   assign accept   = bus.start && (bus.image_width != 10'd0) && (bus.image_height != 10'd0);
   assign last_pix = (col_q == w_q - 10'd1) && (row_q == h_q - 10'd1);

   // Next-state, counter and pipeline logic for the frame sequencer.
   // NOTE: every signal driven here gets a default first, so no path leaves a
   // value unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      w_d     = w_q;
      h_d     = h_q;
      col_d   = col_q;
      row_d   = row_q;
      addr_d  = addr_q;
      tag_a_d = INVALID_TAG;
      flush_d = flush_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               w_d     = bus.image_width;
               h_d     = bus.image_height;
               col_d   = '0;
               row_d   = '0;
               addr_d  = '0;
               state_d = S_REFRESH;
            end
         end
         S_REFRESH: begin
            tag_a_d = DATA_TAG1;
            state_d = S_STREAM;
         end
         S_STREAM: begin
            if (last_pix) begin
               flush_d = 16'(FLUSH_LINES) * {6'd0, w_q} + 16'd1;
               state_d = S_FLUSH;
            end else begin
               addr_d = addr_q + 1'b1;
               if (col_q == w_q - 10'd1) begin
                  col_d   = '0;
                  row_d   = row_q + 10'd1;
                  tag_a_d = DATA_TAG1;
               end else begin
                  col_d   = col_q + 10'd1;
                  tag_a_d = DATA_TAG0;
               end
            end
         end
         S_FLUSH: begin
            if (flush_q == 16'd0) state_d = S_END;
            else                  flush_d = flush_q - 16'd1;
         end
         S_END: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output word: END word and idle zeros override the pipelined tag/pixel.
   always_comb begin
      data_d = (tag_b_q == INVALID_TAG) ? {tag_b_q, 8'h00} : {tag_b_q, bus.mem_rdata};
      if (state_d == S_END)       data_d = {DATA_END_TAG, 8'h00};
      else if (state_d == S_IDLE) data_d = '0;
   end

   // State, counters, address and output registers with synchronous reset.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         w_q     <= '0;
         h_q     <= '0;
         col_q   <= '0;
         row_q   <= '0;
         addr_q  <= '0;
         tag_a_q <= INVALID_TAG;
         tag_b_q <= INVALID_TAG;
         data_q  <= '0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         w_q     <= w_d;
         h_q     <= h_d;
         col_q   <= col_d;
         row_q   <= row_d;
         addr_q  <= addr_d;
         tag_a_q <= tag_a_d;
         tag_b_q <= tag_a_q;
         data_q  <= data_d;
         flush_q <= flush_d;
      end
   end

   assign bus.mem_addr = addr_q;
   assign bus.data_out = data_q;
   assign bus.refresh  = (state_q == S_REFRESH);
   assign bus.busy     = (state_q != S_IDLE);
   assign bus.done     = (state_q == S_END);

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Bench for pixel_stream_tx: a synchronous RAM model feeds the source, expected
// per-cycle outputs are queued when a frame is requested and compared as the
// frame appears after its refresh pulse.
module tb_pixel_stream_tx;

   localparam int FL = 1;

   typedef struct {
      logic [12:0] word;   // {refresh, busy, done, data_out}
      logic [18:0] addr;
      logic        last;
   } exp_t;

   logic clk;
   logic rst;
   logic [7:0] ram [0:1023];
   exp_t q[$];

   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   refresh_cnt = 0;
   int   last_refresh = 0;
   int   last_end = 0;
   bit   active = 0;
   bit   mon_en = 0;

   pixel_stream_tx_if #(.ADDR_WIDTH(19), .DATA_WIDTH(10)) bus ();

   pixel_stream_tx #(.FLUSH_LINES(FL)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) bus.mem_rdata <= ram[bus.mem_addr[9:0]];

   function automatic logic [7:0] ram_val(input int k);
      return 8'(k * 13 + 7);
   endfunction

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, act, exp);
      end
   endtask

   task automatic push_frame(input int w, input int h);
      exp_t e;
      int   wh;
      int   fw;
      wh = w * h;
      fw = FL * w;
      e.word = {3'b110, 10'h000}; e.addr = '0; e.last = 1'b0;
      q.push_back(e);
      for (int j = 0; j < wh + fw + 2; j++) begin
         logic [9:0] d;
         d = 10'h000;
         if (j >= 2 && j - 2 < wh)
            d = {(((j - 2) % w) == 0) ? 2'd2 : 2'd1, ram_val(j - 2)};
         e.word = {3'b010, d};
         e.addr = 19'((j < wh) ? j : wh - 1);
         e.last = 1'b0;
         q.push_back(e);
      end
      e.word = {3'b011, 10'h300}; e.addr = 19'(wh - 1); e.last = 1'b1;
      q.push_back(e);
   endtask

   task automatic wait_drain(input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         if (q.size() == 0 && !active) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("drain_timeout", 32'(q.size()), 32'd0);
   endtask

   task automatic run_frame(input int w, input int h);
      @(posedge clk); #1;
      push_frame(w, h);
      bus.start        = 1'b1;
      bus.image_width  = 10'(w);
      bus.image_height = 10'(h);
      @(posedge clk); #1;
      bus.start        = 1'b0;
      bus.image_width  = 10'($urandom_range(1, 1023));
      bus.image_height = 10'($urandom_range(1, 1023));
      wait_drain(4000);
   endtask

   // Monitor: compare a queued frame once its refresh appears, else expect idle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (mon_en) begin
            if (!active && bus.refresh && q.size() > 0) begin
               active = 1'b1;
               refresh_cnt++;
               last_refresh = cyc;
            end
            if (active) begin
               e = q.pop_front();
               check("word", {19'd0, bus.refresh, bus.busy, bus.done, bus.data_out}, {19'd0, e.word});
               check("addr", {13'd0, bus.mem_addr}, {13'd0, e.addr});
               if (e.last) begin
                  active = 1'b0;
                  last_end = cyc;
               end
            end else begin
               check("idle", {19'd0, bus.refresh, bus.busy, bus.done, bus.data_out}, 32'd0);
            end
         end
      end
   end

   initial begin
      int  base;
      bit  hit;
      for (int i = 0; i < 1024; i++) ram[i] = ram_val(i);
      rst              = 1'b1;
      bus.start        = 1'b0;
      bus.image_width  = 10'd0;
      bus.image_height = 10'd0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_word", {19'd0, bus.refresh, bus.busy, bus.done, bus.data_out}, 32'd0);
      check("rst_addr", {13'd0, bus.mem_addr}, 32'd0);
      mon_en = 1'b1;

      // Basic frame, degenerate shapes and a larger frame.
      run_frame(4, 3);
      run_frame(1, 1);
      run_frame(1, 4);
      run_frame(7, 1);
      run_frame(37, 5);

      // Start held high: two back-to-back frames with one idle cycle between.
      base = refresh_cnt;
      @(posedge clk); #1;
      push_frame(3, 2);
      push_frame(3, 2);
      bus.start        = 1'b1;
      bus.image_width  = 10'd3;
      bus.image_height = 10'd2;
      hit = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         if (refresh_cnt == base + 2) begin
            hit = 1'b1;
            break;
         end
      end
      if (!hit) check("b2b_timeout", 32'(refresh_cnt - base), 32'd2);
      #1 bus.start = 1'b0;
      check("b2b_gap", 32'(last_refresh - last_end), 32'd2);
      // Start pulse while busy must not add a frame.
      @(posedge clk); #1;
      bus.start        = 1'b1;
      bus.image_width  = 10'd2;
      bus.image_height = 10'd2;
      @(posedge clk); #1;
      bus.start = 1'b0;
      wait_drain(400);
      repeat (4) @(posedge clk);

      // Reset in the middle of STREAM at address 5.
      @(posedge clk); #1;
      push_frame(4, 3);
      bus.start        = 1'b1;
      bus.image_width  = 10'd4;
      bus.image_height = 10'd3;
      @(posedge clk); #1;
      bus.start = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.busy && !bus.refresh && bus.mem_addr == 19'd5) begin
            hit = 1'b1;
            break;
         end
      end
      if (!hit) check("rst_mid_timeout", {13'd0, bus.mem_addr}, 32'd5);
      rst = 1'b1;
      @(posedge clk); #1;
      q.delete();
      active = 1'b0;
      rst    = 1'b0;
      @(negedge clk);
      check("rst_mid_word", {19'd0, bus.refresh, bus.busy, bus.done, bus.data_out}, 32'd0);
      check("rst_mid_addr", {13'd0, bus.mem_addr}, 32'd0);
      repeat (3) @(posedge clk);
      run_frame(4, 3);

      // Zero-sized requests are ignored.
      @(posedge clk); #1;
      bus.start        = 1'b1;
      bus.image_width  = 10'd0;
      bus.image_height = 10'd5;
      @(posedge clk); #1;
      bus.image_width  = 10'd5;
      bus.image_height = 10'd0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      check("zero_busy", {31'd0, bus.busy}, 32'd0);

      check("q_empty", 32'(q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
